// File: rtl/bcd_pkg.sv
// Shared types, constants and helpers for the BCD counter.
//   bcd_digit_t : one BCD nibble
//   BCD_MAX/MIN : digit range ends
//   bcd_clamp   : forces an invalid nibble (>9) to 9
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;
    localparam bcd_digit_t BCD_MIN = 4'd0;

    function automatic bcd_digit_t bcd_clamp(input bcd_digit_t nib);
        return (nib > BCD_MAX) ? BCD_MAX : nib;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit register with ripple carry/borrow.
//   clock_i, resetn_i : clock, async active-low reset
//   clear_i, load_i   : synchronous clear / parallel load (clear wins)
//   load_nib_i        : value to load, clamped to 0..9
//   step_i, up_i      : step this digit, direction (1 = up)
//   digit_o           : registered digit value
//   carry_out_o       : stepping up from 9 (next digit must step)
//   borrow_out_o      : stepping down from 0 (next digit must step)
module bcd_digit
    import bcd_pkg::*;
(
    input  logic       clock_i,
    input  logic       resetn_i,
    input  logic       clear_i,
    input  logic       load_i,
    input  bcd_digit_t load_nib_i,
    input  logic       step_i,
    input  logic       up_i,
    output bcd_digit_t digit_o,
    output logic       carry_out_o,
    output logic       borrow_out_o
);

    bcd_digit_t digit_q, digit_d;
    logic       at_max, at_min;

    assign at_max       = (digit_q == BCD_MAX);
    assign at_min       = (digit_q == BCD_MIN);
    assign carry_out_o  = step_i & up_i & at_max;
    assign borrow_out_o = step_i & ~up_i & at_min;
    assign digit_o      = digit_q;

    always_comb begin
        digit_d = digit_q;
        if (clear_i) begin
            digit_d = BCD_MIN;
        end else if (load_i) begin
            digit_d = bcd_clamp(load_nib_i);
        end else if (step_i) begin
            if (up_i) begin
                digit_d = at_max ? BCD_MIN : digit_q + 4'd1;
            end else begin
                digit_d = at_min ? BCD_MAX : digit_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            digit_q <= BCD_MIN;
        end else begin
            digit_q <= digit_d;
        end
    end

endmodule

// File: rtl/bcd_counter_n.sv
// N-digit BCD up/down counter with load, wrap or saturate, step tally and overflow.
//   clock_i, resetn_i : clock, async active-low reset
//   clear_i           : sync clear of count, tally, overflow (highest priority)
//   load_i, load_val_i: sync parallel load, nibbles >9 clamp to 9
//   enable_i, up_i    : one step per enabled cycle, direction (1 = up)
//   bcd_o             : registered count, digit i in bits [4i+3:4i]
//   tot_o             : accepted steps modulo 2^TOT_W
//   wrap_pulse_o      : high the cycle after a step hit a range end
//   overflow_o        : sticky range-end flag
module bcd_counter_n
    import bcd_pkg::*;
#(
    parameter int unsigned DIGITS = 3,
    parameter bit          WRAP   = 1'b1,
    parameter int unsigned TOT_W  = 8
) (
    input  logic                  clock_i,
    input  logic                  resetn_i,
    input  logic                  clear_i,
    input  logic                  enable_i,
    input  logic                  up_i,
    input  logic                  load_i,
    input  logic [4*DIGITS-1:0]   load_val_i,
    output logic [4*DIGITS-1:0]   bcd_o,
    output logic [TOT_W-1:0]      tot_o,
    output logic                  wrap_pulse_o,
    output logic                  overflow_o
);

    bcd_digit_t          digits [DIGITS];
    logic [DIGITS-1:0]   carry, borrow;
    logic [DIGITS:0]     step_chain;
    logic                step_ok, all_max, all_min, at_limit, range_end;

    logic [TOT_W-1:0]    tot_q, tot_d;
    logic                wrap_pulse_q, wrap_pulse_d;
    logic                overflow_q, overflow_d;

    assign step_ok = enable_i & ~clear_i & ~load_i;

    always_comb begin
        all_max = 1'b1;
        all_min = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            all_max &= (digits[i] == BCD_MAX);
            all_min &= (digits[i] == BCD_MIN);
        end
    end

    // A step from the limit in the current direction is a range-end event.
    assign at_limit = up_i ? all_max : all_min;

    // When saturating, suppress the step into the chain so the digits hold.
    assign step_chain[0] = step_ok & ~(!WRAP & at_limit);

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit u_digit (
            .clock_i      (clock_i),
            .resetn_i     (resetn_i),
            .clear_i      (clear_i),
            .load_i       (load_i),
            .load_nib_i   (load_val_i[4*g +: 4]),
            .step_i       (step_chain[g]),
            .up_i         (up_i),
            .digit_o      (digits[g]),
            .carry_out_o  (carry[g]),
            .borrow_out_o (borrow[g])
        );
        assign step_chain[g+1] = carry[g] | borrow[g];
        assign bcd_o[4*g +: 4] = digits[g];
    end

    // With wrap the top digit's carry/borrow is the event; saturating breaks the chain.
    assign range_end = WRAP ? step_chain[DIGITS] : (step_ok & at_limit);

    always_comb begin
        tot_d        = tot_q;
        overflow_d   = overflow_q | range_end;
        wrap_pulse_d = range_end;
        if (clear_i) begin
            tot_d      = '0;
            overflow_d = 1'b0;
        end else if (step_ok) begin
            tot_d = tot_q + TOT_W'(1);
        end
    end

    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            tot_q        <= '0;
            wrap_pulse_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            tot_q        <= tot_d;
            wrap_pulse_q <= wrap_pulse_d;
            overflow_q   <= overflow_d;
        end
    end

    assign tot_o        = tot_q;
    assign wrap_pulse_o = wrap_pulse_q;
    assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_bcd_counter_n.sv
// Self-checking bench: a wrapping and a saturating 3-digit counter share stimulus
// and are compared every cycle against an integer-valued reference model.
module tb_bcd_counter_n;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        resetn, clear, enable, up, load;
    logic [11:0] load_val;
    logic [11:0] bcd_w, bcd_s;
    logic [7:0]  tot_w, tot_s;
    logic        wp_w, wp_s, ov_w, ov_s;

    bcd_counter_n #(.DIGITS(3), .WRAP(1'b1), .TOT_W(8)) u_dut_wrap (
        .clock_i      (clock),
        .resetn_i     (resetn),
        .clear_i      (clear),
        .enable_i     (enable),
        .up_i         (up),
        .load_i       (load),
        .load_val_i   (load_val),
        .bcd_o        (bcd_w),
        .tot_o        (tot_w),
        .wrap_pulse_o (wp_w),
        .overflow_o   (ov_w)
    );

    bcd_counter_n #(.DIGITS(3), .WRAP(1'b0), .TOT_W(8)) u_dut_sat (
        .clock_i      (clock),
        .resetn_i     (resetn),
        .clear_i      (clear),
        .enable_i     (enable),
        .up_i         (up),
        .load_i       (load),
        .load_val_i   (load_val),
        .bcd_o        (bcd_s),
        .tot_o        (tot_s),
        .wrap_pulse_o (wp_s),
        .overflow_o   (ov_s)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: index 0 = saturating, 1 = wrapping. Count held as an integer.
    int m_val [2];
    int m_tot [2];
    bit m_ovf [2];
    bit m_wp  [2];

    typedef struct {
        bit          c, l, e, u;
        logic [11:0] lv;
        logic [11:0] exp_bcd;
        bit          exp_wp;
    } vec_t;
    vec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] to_bcd(input int v);
        return {4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic int load_to_int(input logic [11:0] lv);
        int v = 0;
        int scale = 1;
        for (int i = 0; i < 3; i++) begin
            int nib = int'((lv >> (4 * i)) & 12'hF);
            v += ((nib > 9) ? 9 : nib) * scale;
            scale *= 10;
        end
        return v;
    endfunction

    task automatic model_reset();
        for (int w = 0; w < 2; w++) begin
            m_val[w] = 0; m_tot[w] = 0; m_ovf[w] = 0; m_wp[w] = 0;
        end
    endtask

    task automatic model_edge();
        for (int w = 0; w < 2; w++) begin
            m_wp[w] = 0;
            if (clear) begin
                m_val[w] = 0; m_tot[w] = 0; m_ovf[w] = 0;
            end else if (load) begin
                m_val[w] = load_to_int(load_val);
            end else if (enable) begin
                m_tot[w] = (m_tot[w] + 1) % 256;
                if (up) begin
                    if (m_val[w] == 999) begin
                        m_wp[w] = 1; m_ovf[w] = 1;
                        m_val[w] = (w == 1) ? 0 : 999;
                    end else begin
                        m_val[w] = m_val[w] + 1;
                    end
                end else begin
                    if (m_val[w] == 0) begin
                        m_wp[w] = 1; m_ovf[w] = 1;
                        m_val[w] = (w == 1) ? 999 : 0;
                    end else begin
                        m_val[w] = m_val[w] - 1;
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        chk("wrap_bcd", 32'(bcd_w), 32'(to_bcd(m_val[1])));
        chk("wrap_tot", 32'(tot_w), 32'(m_tot[1]));
        chk("wrap_pulse", 32'(wp_w), 32'(m_wp[1]));
        chk("wrap_ovf", 32'(ov_w), 32'(m_ovf[1]));
        chk("sat_bcd", 32'(bcd_s), 32'(to_bcd(m_val[0])));
        chk("sat_tot", 32'(tot_s), 32'(m_tot[0]));
        chk("sat_pulse", 32'(wp_s), 32'(m_wp[0]));
        chk("sat_ovf", 32'(ov_s), 32'(m_ovf[0]));
    endtask

    // Inputs are already stable; advance one edge, update the model, sample 1 ns later.
    task automatic cycle();
        @(posedge clock);
        if (!resetn) model_reset();
        else model_edge();
        #1;
        check_all();
    endtask

    task automatic set_in(input bit c, input bit l, input bit e, input bit u,
                          input logic [11:0] lv);
        clear = c; load = l; enable = e; up = u; load_val = lv;
    endtask

    initial begin
        tbl[0]  = '{1, 0, 0, 0, 12'h000, 12'h000, 0};
        tbl[1]  = '{0, 1, 0, 0, 12'h099, 12'h099, 0};
        tbl[2]  = '{0, 0, 1, 1, 12'h000, 12'h100, 0};
        tbl[3]  = '{0, 0, 1, 0, 12'h000, 12'h099, 0};
        tbl[4]  = '{0, 1, 0, 0, 12'hAF9, 12'h999, 0};
        tbl[5]  = '{0, 0, 1, 1, 12'h000, 12'h000, 1};
        tbl[6]  = '{0, 0, 1, 0, 12'h000, 12'h999, 1};
        tbl[7]  = '{0, 0, 0, 0, 12'h000, 12'h999, 0};
        tbl[8]  = '{0, 1, 0, 0, 12'h123, 12'h123, 0};
        tbl[9]  = '{1, 1, 1, 1, 12'h777, 12'h000, 0};
        tbl[10] = '{0, 0, 1, 0, 12'h000, 12'h999, 1};
        tbl[11] = '{0, 1, 0, 0, 12'h5A0, 12'h590, 0};

        resetn = 1'b0;
        set_in(0, 0, 0, 0, 12'h000);
        model_reset();
        #2;
        check_all();
        @(posedge clock);
        #1;
        resetn = 1'b1;

        // Count up through the full range and across the wrap.
        set_in(0, 0, 1, 1, 12'h000);
        for (int i = 0; i < 1000; i++) begin
            cycle();
            if (i == 998) begin
                chk("t1_bcd_999", 32'(bcd_w), 32'h999);
                chk("t1_no_pulse_early", 32'(wp_w), 32'd0);
            end
        end
        chk("t1_bcd_wrapped", 32'(bcd_w), 32'h000);
        chk("t1_tot", 32'(tot_w), 32'd232);
        chk("t1_pulse", 32'(wp_w), 32'd1);
        chk("t1_ovf", 32'(ov_w), 32'd1);
        chk("t1_sat_held", 32'(bcd_s), 32'h999);

        // Load 500, count down into the saturating floor.
        set_in(1, 0, 0, 0, 12'h000);
        cycle();
        set_in(0, 1, 0, 0, 12'h500);
        cycle();
        set_in(0, 0, 1, 0, 12'h000);
        for (int i = 1; i <= 501; i++) begin
            cycle();
            if (i == 500) begin
                chk("t2_bcd_zero", 32'(bcd_s), 32'h000);
                chk("t2_no_pulse_yet", 32'(wp_s), 32'd0);
            end
        end
        chk("t2_bcd_held", 32'(bcd_s), 32'h000);
        chk("t2_pulse", 32'(wp_s), 32'd1);
        chk("t2_tot", 32'(tot_s), 32'd245);
        chk("t2_ovf", 32'(ov_s), 32'd1);
        chk("t2_wrap_dut", 32'(bcd_w), 32'h999);

        // Table: ripple carries, clamped load, wrap both ways, priority.
        for (int i = 0; i < 12; i++) begin
            set_in(tbl[i].c, tbl[i].l, tbl[i].e, tbl[i].u, tbl[i].lv);
            cycle();
            chk($sformatf("tbl%0d_bcd", i), 32'(bcd_w), 32'(tbl[i].exp_bcd));
            chk($sformatf("tbl%0d_pulse", i), 32'(wp_w), 32'(tbl[i].exp_wp));
        end

        // Async reset between edges, then resume counting.
        set_in(0, 1, 0, 0, 12'h456);
        cycle();
        set_in(0, 0, 1, 1, 12'h000);
        cycle();
        chk("t6_bcd_457", 32'(bcd_w), 32'h457);
        #2;
        resetn = 1'b0;
        #1;
        model_reset();
        chk("t6_async_bcd", 32'(bcd_w), 32'h000);
        chk("t6_async_tot", 32'(tot_w), 32'd0);
        check_all();
        cycle();
        resetn = 1'b1;
        cycle();
        chk("t6_resume", 32'(bcd_w), 32'h001);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            set_in(($urandom % 40) == 0, ($urandom % 12) == 0, ($urandom % 4) != 0,
                   ($urandom % 2) == 1, 12'($urandom));
            if (($urandom % 8) == 0) load_val = (($urandom % 2) == 1) ? 12'h999 : 12'h001;
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
